// File: rtl/phys332_pkg.sv
// Shared constants for the 7-segment display path.
//   SEG_HEX   : active-low {CG,CF,CE,CD,CC,CB,CA} patterns for hex digits 0..F
//   SEG_BLANK : all segments off
//   hex_to_seg: nibble -> active-low segment pattern
package phys332_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/debounced_updown_counter_display_debounce_edge.sv
// Button conditioning: 2-flop synchroniser, counting debouncer and a one-cycle
// registered pulse on each accepted 0->1 transition of the stable level.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   btn_raw in  raw asynchronous button level
//   press   out one-cycle pulse per accepted press
module debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);
    import phys332_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pulse_r;
    logic             differ_s;
    logic             accept_s;

    // Acceptance happens on the cycle the counter has seen a full stable window.
    always_comb begin
        differ_s = sync_r[1] ^ stable_r;
        accept_s = differ_s && (cnt_r == CNT_LAST);
    end

    // Synchroniser, debounce counter, stable level and rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 2'b00;
            stable_r <= 1'b0;
            cnt_r    <= '0;
            pulse_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], btn_raw};
            // Pulse is produced alongside the 0->1 update so the count moves one cycle later.
            pulse_r <= accept_s & sync_r[1];
            if (!differ_s) begin
                cnt_r <= '0;
            end else if (accept_s) begin
                stable_r <= sync_r[1];
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press = pulse_r;

endmodule

// File: rtl/debounced_updown_counter_display.sv
// Debounced up/down/clear counter with a multiplexed hex 7-segment display.
// Ports:
//   CLK100MHZ  in  system clock
//   CPU_RESETN in  asynchronous active-low reset
//   btn_up/btn_dn/btn_clr in raw button levels
//   count      out registered counter value
//   AN         out active-low digit anodes (one digit low at a time)
//   SEG        out active-low {CG..CA}
//   DP         out decimal point, always off
module debounced_updown_counter_display #(
    parameter int WIDTH           = 32,
    parameter int N_DIGITS        = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SCAN_DIV        = 12_500,
    parameter bit SATURATE        = 1'b0,
    parameter bit LEAD_BLANK      = 1'b0
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic                btn_up,
    input  logic                btn_dn,
    input  logic                btn_clr,
    output logic [WIDTH-1:0]    count,
    output logic [N_DIGITS-1:0] AN,
    output logic [6:0]          SEG,
    output logic                DP
);
    import phys332_pkg::*;

    localparam int PAD_W  = 4 * N_DIGITS;
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [WIDTH-1:0]  COUNT_MAX = '1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic                up_s, dn_s, clr_s;
    logic [WIDTH-1:0]    count_r, count_next_s;
    logic [SCAN_W-1:0]   scan_cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [N_DIGITS-1:0] an_r, an_next_s;
    logic [6:0]          seg_r, seg_next_s;
    logic [PAD_W-1:0]    padded_s;
    logic [3:0]          nibble_s;
    logic                upper_zero_s;

    debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(CLK100MHZ), .rst_n(CPU_RESETN), .btn_raw(btn_up), .press(up_s)
    );
    debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk(CLK100MHZ), .rst_n(CPU_RESETN), .btn_raw(btn_dn), .press(dn_s)
    );
    debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(CLK100MHZ), .rst_n(CPU_RESETN), .btn_raw(btn_clr), .press(clr_s)
    );

    // Next count: clear wins, simultaneous up+dn cancel, then wrap or clamp.
    always_comb begin
        count_next_s = count_r;
        if (clr_s) begin
            count_next_s = '0;
        end else if (up_s && !dn_s) begin
            if (SATURATE && (count_r == COUNT_MAX)) begin
                count_next_s = count_r;
            end else begin
                count_next_s = count_r + WIDTH'(1);
            end
        end else if (dn_s && !up_s) begin
            if (SATURATE && (count_r == '0)) begin
                count_next_s = count_r;
            end else begin
                count_next_s = count_r - WIDTH'(1);
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Digit pattern for the current scan index; nibbles beyond WIDTH read as zero.
    always_comb begin
        padded_s               = '0;
        padded_s[WIDTH-1:0]    = count_r;
        nibble_s               = padded_s[{idx_r, 2'b00} +: 4];
        upper_zero_s           = ((padded_s >> {idx_r, 2'b00}) == '0);
        an_next_s              = ~(N_DIGITS'(1) << idx_r);
        if (LEAD_BLANK && (idx_r != '0) && upper_zero_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = hex_to_seg(nibble_s);
        end
    end

    // Counter register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            count_r <= '0;
        end else begin
            count_r <= count_next_s;
        end
    end

    // Scan divider and digit index.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            scan_cnt_r <= '0;
            idx_r      <= '0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Registered display outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            an_r  <= '1;
            seg_r <= SEG_BLANK;
        end else begin
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
        end
    end

    assign count = count_r;
    assign AN    = an_r;
    assign SEG   = seg_r;
    assign DP    = 1'b1;

endmodule

// File: tb/tb_debounced_updown_counter_display.sv
module tb_debounced_updown_counter_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up = 1'b0, btn_dn = 1'b0, btn_clr = 1'b0;

    // Instance 1: wrapping, no blanking. Instance 2: saturating, leading-zero blanking.
    logic [7:0] count1, count2;
    logic [1:0] an1, an2;
    logic [6:0] seg1, seg2;
    logic       dp1, dp2;

    always #5 clk = ~clk;

    debounced_updown_counter_display #(
        .WIDTH(8), .N_DIGITS(2), .DEBOUNCE_CYCLES(4), .SCAN_DIV(2),
        .SATURATE(1'b0), .LEAD_BLANK(1'b0)
    ) dut_wrap (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .btn_up(btn_up), .btn_dn(btn_dn),
        .btn_clr(btn_clr), .count(count1), .AN(an1), .SEG(seg1), .DP(dp1)
    );

    debounced_updown_counter_display #(
        .WIDTH(8), .N_DIGITS(2), .DEBOUNCE_CYCLES(4), .SCAN_DIV(2),
        .SATURATE(1'b1), .LEAD_BLANK(1'b1)
    ) dut_sat (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .btn_up(btn_up), .btn_dn(btn_dn),
        .btn_clr(btn_clr), .count(count2), .AN(an2), .SEG(seg2), .DP(dp2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      name;
        logic [7:0] e_wrap;
        logic [7:0] e_sat;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [2:0] btn;     // {clr, dn, up}
        logic [7:0] e_wrap;
        logic [7:0] e_sat;
    } vec_t;
    vec_t vecs[8];

    logic [7:0] m_wrap = 8'h00;
    logic [7:0] m_sat  = 8'h00;

    // Count changes of the wrapping counter, sampled away from the active edge.
    int         changes = 0;
    logic [7:0] prev1   = 8'h00;
    always @(negedge clk) begin
        if (count1 !== prev1) changes++;
        prev1 = count1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        @(negedge clk);
        {btn_clr, btn_dn, btn_up} = m;
        repeat (hold) @(negedge clk);
        {btn_clr, btn_dn, btn_up} = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    task automatic model_step(input logic [2:0] m);
        if (m[2]) begin
            m_wrap = 8'h00;
            m_sat  = 8'h00;
        end else if (m[0] && !m[1]) begin
            m_wrap = m_wrap + 8'd1;
            if (m_sat != 8'hFF) m_sat = m_sat + 8'd1;
        end else if (m[1] && !m[0]) begin
            m_wrap = m_wrap - 8'd1;
            if (m_sat != 8'h00) m_sat = m_sat - 8'd1;
        end
    endtask

    task automatic sb_push(input string name, input logic [7:0] ew, input logic [7:0] es);
        sb_t e;
        e.name = name; e.e_wrap = ew; e.e_sat = es;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.name, "_wrap"}, {24'd0, count1}, {24'd0, e.e_wrap});
            chk({e.name, "_sat"},  {24'd0, count2}, {24'd0, e.e_sat});
        end
    endtask

    // Press, predict with the model, then compare once the count has settled.
    task automatic do_press(input logic [2:0] m, input string name);
        press(m, 10);
        model_step(m);
        sb_push(name, m_wrap, m_sat);
        sb_check();
    endtask

    // Quiet press used to walk the count without a compare per step.
    task automatic walk(input logic [2:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            press(m, 10);
            model_step(m);
        end
    endtask

    // Watch 8 cycles of scanning on one instance; SCAN_DIV=2 gives 4 cycles per digit.
    task automatic check_display(input string name, input bit sat_inst,
                                 input logic [6:0] seg_d0, input logic [6:0] seg_d1);
        int n0 = 0;
        int n1 = 0;
        logic [1:0] a;
        logic [6:0] s;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a = sat_inst ? an2 : an1;
            s = sat_inst ? seg2 : seg1;
            if (a == 2'b10) begin
                n0++;
                chk({name, "_d0"}, {25'd0, s}, {25'd0, seg_d0});
            end else if (a == 2'b01) begin
                n1++;
                chk({name, "_d1"}, {25'd0, s}, {25'd0, seg_d1});
            end else begin
                chk({name, "_an"}, {30'd0, a}, 32'h2);
            end
        end
        chk({name, "_d0_cycles"}, n0, 4);
        chk({name, "_d1_cycles"}, n1, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        vecs[0] = '{3'b100, 8'h00, 8'h00};  // clear
        vecs[1] = '{3'b010, 8'hFF, 8'h00};  // dn at 0: wrap vs hold
        vecs[2] = '{3'b001, 8'h00, 8'h01};  // up at FF wraps to 0
        vecs[3] = '{3'b011, 8'h00, 8'h01};  // up+dn together: no change
        vecs[4] = '{3'b001, 8'h01, 8'h02};
        vecs[5] = '{3'b010, 8'h00, 8'h01};
        vecs[6] = '{3'b010, 8'hFF, 8'h00};
        vecs[7] = '{3'b110, 8'h00, 8'h00};  // clear beats dn

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_count", {24'd0, count1}, 32'h00);
        chk("reset_an",    {30'd0, an1},    32'h3);
        chk("reset_seg",   {25'd0, seg1},   32'h7F);
        chk("reset_dp",    {31'd0, dp1},    32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_an_after_reset", {30'd0, an1}, 32'h2);
        repeat (4) @(negedge clk);

        // Bounce: toggling faster than the debounce window, then a steady hold
        c0 = changes;
        for (int k = 0; k < 10; k++) begin
            btn_up = ~k[0];
            repeat (2) @(negedge clk);
        end
        btn_up = 1'b1;
        repeat (20) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        model_step(3'b001);
        sb_push("bounce", m_wrap, m_sat);
        sb_check();
        chk("bounce_changes", changes - c0, 1);

        // Hold then clean repeats
        do_press(3'b100, "clr_before_hold");
        press(3'b001, 100);
        model_step(3'b001);
        sb_push("hold_100", m_wrap, m_sat);
        sb_check();
        walk(3'b001, 3);
        sb_push("three_presses", 8'h04, 8'h04);
        sb_check();

        // Table-driven sequence
        for (int i = 0; i < 8; i++) begin
            press(vecs[i].btn, 10);
            sb_push($sformatf("vec%0d", i), vecs[i].e_wrap, vecs[i].e_sat);
            m_wrap = vecs[i].e_wrap;
            m_sat  = vecs[i].e_sat;
            sb_check();
        end

        // Clear and up together at 0x12
        walk(3'b001, 18);
        sb_push("reach_12", 8'h12, 8'h12);
        sb_check();
        do_press(3'b101, "clr_up_at_12");
        chk("clr_up_is_zero", {24'd0, count1}, 32'h00);

        // Display of 0x3A on both instances
        walk(3'b001, 58);
        sb_push("reach_3a", 8'h3A, 8'h3A);
        sb_check();
        check_display("disp_3a_wrap", 1'b0, 7'h08, 7'h30);
        check_display("disp_3a_sat",  1'b1, 7'h08, 7'h30);

        // Leading-zero blanking with 0x05
        do_press(3'b100, "clr_before_05");
        walk(3'b001, 5);
        sb_push("reach_05", 8'h05, 8'h05);
        sb_check();
        check_display("disp_05_noblank", 1'b0, 7'h12, 7'h40);
        check_display("disp_05_blank",   1'b1, 7'h12, 7'h7F);

        // Saturation at the top
        do_press(3'b100, "clr_before_top");
        walk(3'b001, 255);
        sb_push("reach_ff", 8'hFF, 8'hFF);
        sb_check();
        do_press(3'b001, "up_at_ff");
        do_press(3'b001, "up_after_wrap");

        // Reset while btn_up is partly debounced; released before reset ends
        @(negedge clk);
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_count", {24'd0, count1}, 32'h00);
        chk("midreset_an",    {30'd0, an1},    32'h3);
        chk("midreset_seg",   {25'd0, seg1},   32'h7F);
        repeat (2) @(negedge clk);
        btn_up = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_wrap = 8'h00;
        m_sat  = 8'h00;
        @(negedge clk);
        chk("an_after_midreset", {30'd0, an1}, 32'h2);
        repeat (20) @(negedge clk);
        sb_push("released_in_reset", m_wrap, m_sat);
        sb_check();

        // Button held across reset release counts once
        @(negedge clk);
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        model_step(3'b001);
        sb_push("held_through_reset", m_wrap, m_sat);
        sb_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
